// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared feature word/vector types and deserializer FSM states
package cnn_pkg;

    localparam int FEATURE_WIDTH  = 16;
    localparam int FEATURES_DEPTH = 6;
    localparam int IDX_W          = (FEATURES_DEPTH > 1) ? $clog2(FEATURES_DEPTH) : 1;

    typedef logic signed [FEATURE_WIDTH-1:0] feature_t;
    typedef feature_t [0:FEATURES_DEPTH-1]   feature_vec_t;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/pin_deserializer.sv
// rtl/pin_deserializer.sv - assembles narrow pin words into parallel feature vectors
module pin_deserializer
    import cnn_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     pin_valid,
    input  feature_t pin_data,
    input  logic     pin_last,
    output logic     pin_ready,
    output logic     features_valid,
    output feature_t features_out [0:FEATURES_DEPTH-1],
    input  logic     features_ready,
    output logic     short_frame
);

    state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    feature_vec_t asm_q, asm_d;
    feature_vec_t out_q, out_d;
    logic         fvalid_q, fvalid_d;
    logic         held_short_q, held_short_d;
    logic         short_q, short_d;

    feature_vec_t cand_vec;
    logic         beat;
    logic         last_lane;
    logic         done;
    logic         is_short;
    logic         out_free;

    // Ready depends only on registered state, so no path from features_ready.
    assign pin_ready      = (state_q == FILL);
    assign features_valid = fvalid_q;
    assign short_frame    = short_q;

    for (genvar g = 0; g < FEATURES_DEPTH; g++) begin : g_out
        assign features_out[g] = out_q[g];
    end

    assign beat      = pin_valid & pin_ready;
    assign last_lane = (idx_q == IDX_W'(FEATURES_DEPTH - 1));
    assign done      = beat & (last_lane | pin_last);
    assign is_short  = pin_last & ~last_lane;
    assign out_free  = ~fvalid_q | features_ready;

    // Current assembly with the incoming word at idx and all higher lanes cleared.
    always_comb begin
        cand_vec = '0;
        for (int j = 0; j < FEATURES_DEPTH; j++) begin
            if (j < int'(idx_q)) begin
                cand_vec[j] = asm_q[j];
            end else if (j == int'(idx_q)) begin
                cand_vec[j] = pin_data;
            end else begin
                cand_vec[j] = '0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        out_d        = out_q;
        fvalid_d     = fvalid_q;
        held_short_d = held_short_q;
        short_d      = 1'b0;

        case (state_q)
            FILL: begin
                if (fvalid_q && features_ready) begin
                    fvalid_d = 1'b0;
                end
                if (beat) begin
                    asm_d = cand_vec;
                    idx_d = done ? '0 : idx_q + 1'b1;
                end
                if (done) begin
                    if (out_free) begin
                        out_d    = cand_vec;
                        fvalid_d = 1'b1;
                        short_d  = is_short;
                    end else begin
                        held_short_d = is_short;
                        state_d      = STALL;
                    end
                end
            end
            STALL: begin
                if (features_ready && fvalid_q) begin
                    out_d    = asm_q;
                    fvalid_d = 1'b1;
                    short_d  = held_short_q;
                    idx_d    = '0;
                    state_d  = FILL;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            idx_q        <= '0;
            asm_q        <= '0;
            out_q        <= '0;
            fvalid_q     <= 1'b0;
            held_short_q <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            out_q        <= out_d;
            fvalid_q     <= fvalid_d;
            held_short_q <= held_short_d;
            short_q      <= short_d;
        end
    end

endmodule

// File: tb/tb_pin_deserializer.sv
// tb/tb_pin_deserializer.sv - directed self-checking bench for pin_deserializer
module tb_pin_deserializer;
    import cnn_pkg::*;

    localparam int D = FEATURES_DEPTH;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     pin_valid;
    feature_t pin_data;
    logic     pin_last;
    logic     pin_ready;
    logic     features_valid;
    feature_t features_out [0:D-1];
    logic     features_ready;
    logic     short_frame;

    feature_t exp_v [0:D-1];
    int       checks = 0;
    int       errors = 0;

    pin_deserializer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pin_valid      (pin_valid),
        .pin_data       (pin_data),
        .pin_last       (pin_last),
        .pin_ready      (pin_ready),
        .features_valid (features_valid),
        .features_out   (features_out),
        .features_ready (features_ready),
        .short_frame    (short_frame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d, input logic l);
        pin_valid = v;
        pin_data  = feature_t'(d);
        pin_last  = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        features_ready = 1'b0;
        drive(1'b0, 0, 1'b0);
        step();
        step();
        checks++; if (pin_ready !== 1'b1) begin errors++; $display("FAIL reset pin_ready: got %b expected 1", pin_ready); end
        checks++; if (features_valid !== 1'b0) begin errors++; $display("FAIL reset features_valid: got %b expected 0", features_valid); end
        checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL reset short_frame: got %b expected 0", short_frame); end
        for (int j = 0; j < D; j++) begin
            checks++;
            if (features_out[j] !== '0) begin errors++; $display("FAIL reset lane %0d: got %0d expected 0", j, features_out[j]); end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_vector();
        features_ready = 1'b1;
        for (int i = 1; i <= D; i++) begin
            checks++; if (pin_ready !== 1'b1) begin errors++; $display("FAIL single pin_ready word %0d: got %b expected 1", i, pin_ready); end
            drive(1'b1, i, 1'b0);
            step();
            if (i < D) begin
                checks++; if (features_valid !== 1'b0) begin errors++; $display("FAIL single early valid word %0d: got %b expected 0", i, features_valid); end
            end
        end
        drive(1'b0, 0, 1'b0);
        for (int j = 0; j < D; j++) exp_v[j] = feature_t'(j + 1);
        checks++; if (features_valid !== 1'b1) begin errors++; $display("FAIL single valid: got %b expected 1", features_valid); end
        checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL single short_frame: got %b expected 0", short_frame); end
        for (int j = 0; j < D; j++) begin
            checks++;
            if (features_out[j] !== exp_v[j]) begin errors++; $display("FAIL single lane %0d: got %0d expected %0d", j, features_out[j], exp_v[j]); end
        end
        step();
        checks++; if (features_valid !== 1'b0) begin errors++; $display("FAIL single drain valid: got %b expected 0", features_valid); end
    endtask

    task automatic test_back_to_back();
        features_ready = 1'b1;
        for (int k = 1; k <= 2 * D; k++) begin
            checks++; if (pin_ready !== 1'b1) begin errors++; $display("FAIL b2b pin_ready word %0d: got %b expected 1", k, pin_ready); end
            drive(1'b1, -k, 1'b0);
            step();
            checks++;
            if (features_valid !== ((k % D) == 0)) begin errors++; $display("FAIL b2b valid after word %0d: got %b expected %b", k, features_valid, ((k % D) == 0)); end
            if ((k % D) == 0) begin
                for (int j = 0; j < D; j++) exp_v[j] = feature_t'(-(k - D + j + 1));
                for (int j = 0; j < D; j++) begin
                    checks++;
                    if (features_out[j] !== exp_v[j]) begin errors++; $display("FAIL b2b vec %0d lane %0d: got %0d expected %0d", k / D, j, features_out[j], exp_v[j]); end
                end
            end
        end
        drive(1'b0, 0, 1'b0);
        step();
        checks++; if (features_valid !== 1'b0) begin errors++; $display("FAIL b2b drain valid: got %b expected 0", features_valid); end
    endtask

    task automatic test_stall();
        features_ready = 1'b0;
        for (int k = 1; k <= 2 * D; k++) begin
            checks++; if (pin_ready !== 1'b1) begin errors++; $display("FAIL stall pin_ready word %0d: got %b expected 1", k, pin_ready); end
            drive(1'b1, k, 1'b0);
            step();
        end
        for (int j = 0; j < D; j++) exp_v[j] = feature_t'(j + 1);
        checks++; if (pin_ready !== 1'b0) begin errors++; $display("FAIL stall pin_ready held: got %b expected 0", pin_ready); end
        checks++; if (features_valid !== 1'b1) begin errors++; $display("FAIL stall valid: got %b expected 1", features_valid); end
        drive(1'b1, 999, 1'b0);
        step();
        step();
        checks++; if (pin_ready !== 1'b0) begin errors++; $display("FAIL stall pin_ready still: got %b expected 0", pin_ready); end
        for (int j = 0; j < D; j++) begin
            checks++;
            if (features_out[j] !== exp_v[j]) begin errors++; $display("FAIL stall hold lane %0d: got %0d expected %0d", j, features_out[j], exp_v[j]); end
        end
        features_ready = 1'b1;
        step();
        features_ready = 1'b0;
        drive(1'b0, 0, 1'b0);
        for (int j = 0; j < D; j++) exp_v[j] = feature_t'(D + j + 1);
        checks++; if (features_valid !== 1'b1) begin errors++; $display("FAIL stall release valid: got %b expected 1", features_valid); end
        checks++; if (pin_ready !== 1'b1) begin errors++; $display("FAIL stall release pin_ready: got %b expected 1", pin_ready); end
        checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL stall release short_frame: got %b expected 0", short_frame); end
        for (int j = 0; j < D; j++) begin
            checks++;
            if (features_out[j] !== exp_v[j]) begin errors++; $display("FAIL stall release lane %0d: got %0d expected %0d", j, features_out[j], exp_v[j]); end
        end
        step();
        checks++; if (features_valid !== 1'b1) begin errors++; $display("FAIL stall second hold valid: got %b expected 1", features_valid); end
        features_ready = 1'b1;
        step();
        checks++; if (features_valid !== 1'b0) begin errors++; $display("FAIL stall drain valid: got %b expected 0", features_valid); end
    endtask

    task automatic test_short_frame();
        features_ready = 1'b1;
        drive(1'b1, 5, 1'b0);
        step();
        drive(1'b1, 6, 1'b0);
        step();
        drive(1'b1, 7, 1'b1);
        step();
        drive(1'b0, 0, 1'b0);
        exp_v[0] = 16'sd5; exp_v[1] = 16'sd6; exp_v[2] = 16'sd7;
        for (int j = 3; j < D; j++) exp_v[j] = '0;
        checks++; if (features_valid !== 1'b1) begin errors++; $display("FAIL short valid: got %b expected 1", features_valid); end
        checks++; if (short_frame !== 1'b1) begin errors++; $display("FAIL short pulse: got %b expected 1", short_frame); end
        for (int j = 0; j < D; j++) begin
            checks++;
            if (features_out[j] !== exp_v[j]) begin errors++; $display("FAIL short lane %0d: got %0d expected %0d", j, features_out[j], exp_v[j]); end
        end
        step();
        checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL short pulse width: got %b expected 0", short_frame); end
        checks++; if (features_valid !== 1'b0) begin errors++; $display("FAIL short drain valid: got %b expected 0", features_valid); end
        drive(1'b1, 8, 1'b1);
        step();
        drive(1'b0, 0, 1'b0);
        exp_v[0] = 16'sd8;
        for (int j = 1; j < D; j++) exp_v[j] = '0;
        checks++; if (short_frame !== 1'b1) begin errors++; $display("FAIL short lane0 pulse: got %b expected 1", short_frame); end
        for (int j = 0; j < D; j++) begin
            checks++;
            if (features_out[j] !== exp_v[j]) begin errors++; $display("FAIL short lane0 vec lane %0d: got %0d expected %0d", j, features_out[j], exp_v[j]); end
        end
        step();
    endtask

    task automatic test_reset_mid_vector();
        features_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 100 + k, 1'b0);
            step();
        end
        drive(1'b0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (features_valid !== 1'b0) begin errors++; $display("FAIL midrst valid: got %b expected 0", features_valid); end
        checks++; if (pin_ready !== 1'b1) begin errors++; $display("FAIL midrst pin_ready: got %b expected 1", pin_ready); end
        for (int j = 0; j < D; j++) begin
            checks++;
            if (features_out[j] !== '0) begin errors++; $display("FAIL midrst lane %0d: got %0d expected 0", j, features_out[j]); end
        end
        step();
        checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL midrst short_frame: got %b expected 0", short_frame); end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < D; k++) begin
            drive(1'b1, 200 + k, 1'b0);
            step();
            checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL midrst new short word %0d: got %b expected 0", k, short_frame); end
        end
        drive(1'b0, 0, 1'b0);
        for (int j = 0; j < D; j++) exp_v[j] = feature_t'(200 + j);
        checks++; if (features_valid !== 1'b1) begin errors++; $display("FAIL midrst new valid: got %b expected 1", features_valid); end
        for (int j = 0; j < D; j++) begin
            checks++;
            if (features_out[j] !== exp_v[j]) begin errors++; $display("FAIL midrst new lane %0d: got %0d expected %0d", j, features_out[j], exp_v[j]); end
        end
        step();
    endtask

    task automatic test_random_stream();
        int       sent = 0;
        int       got = 0;
        int       cyc = 0;
        int       extra = 0;
        logic     acc;
        logic     cons;
        feature_t snap [0:D-1];
        while (got < 10 && cyc < 3000) begin
            if (sent < 60 && $urandom_range(0, 1) == 1) drive(1'b1, 3000 + sent, 1'b0);
            else drive(1'b0, 0, 1'b0);
            features_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = pin_valid && pin_ready;
            cons = features_valid && features_ready;
            for (int j = 0; j < D; j++) snap[j] = features_out[j];
            step();
            cyc++;
            if (acc) sent++;
            if (cons) begin
                for (int j = 0; j < D; j++) begin
                    checks++;
                    if (snap[j] !== feature_t'(3000 + got * D + j)) begin
                        errors++;
                        $display("FAIL random vec %0d lane %0d: got %0d expected %0d", got, j, snap[j], 3000 + got * D + j);
                    end
                end
                got++;
            end
        end
        drive(1'b0, 0, 1'b0);
        features_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (features_valid) extra++;
            step();
        end
        checks++; if (got !== 10) begin errors++; $display("FAIL random vector count: got %0d expected 10", got); end
        checks++; if (sent !== 60) begin errors++; $display("FAIL random words sent: got %0d expected 60", sent); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL random duplicate vectors: got %0d expected 0", extra); end
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_back_to_back();
        test_stall();
        test_short_frame();
        test_reset_mid_vector();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
